sdram_line_reader: RTL



---
 rtl/sdram_line_reader.sv | 100 ++++++++++
 1 files changed

// File: rtl/sdram_line_reader.sv
// Turns 128-bit line read requests into 8 pipelined 16-bit Avalon-MM reads and
// assembles the returned beats into one line, strobing ac when it is complete.
module sdram_line_reader #(
    parameter int BEATS          = 8,
    parameter int STARTUP_CYCLES = 100
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic [21:0]  addr,
    output logic         wait_o,
    output logic         ac,
    output logic [127:0] data,
    output logic [24:0]  avm_address,
    output logic         avm_read,
    output logic [1:0]   avm_byteenable,
    input  logic         avm_waitrequest,
    input  logic [15:0]  avm_readdata,
    input  logic         avm_readdatavalid
);

    localparam int SW = $clog2(STARTUP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_STARTUP,
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state, state_next;
    logic [SW-1:0] startup_cnt;
    logic [21:0]   line_addr;
    logic [3:0]    issue_cnt;
    logic [3:0]    rcv_cnt;
    logic          issue_accept;
    logic          beat_capture;
    logic          last_beat;

    // Beats are only captured while a line is in flight; rcv_cnt saturates at BEATS.
    always_comb begin
        issue_accept = (state == S_ISSUE) && !avm_waitrequest;
        beat_capture = ((state == S_ISSUE) || (state == S_DRAIN)) &&
                       avm_readdatavalid && (rcv_cnt < 4'(BEATS));
        last_beat    = beat_capture && (rcv_cnt == 4'(BEATS - 1));
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_STARTUP: if (startup_cnt == SW'(STARTUP_CYCLES - 1)) state_next = S_IDLE;
            S_IDLE:    if (rd) state_next = S_ISSUE;
            S_ISSUE: begin
                if (last_beat)
                    state_next = S_DONE;
                else if (issue_accept && (issue_cnt == 4'(BEATS - 1)))
                    state_next = S_DRAIN;
            end
            S_DRAIN:   if (last_beat) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_STARTUP;
        endcase
    end

    always_comb begin
        wait_o         = (state != S_IDLE);
        ac             = (state == S_DONE);
        avm_read       = (state == S_ISSUE);
        avm_address    = {line_addr, 3'b000} + 25'(issue_cnt);
        avm_byteenable = 2'b11;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_STARTUP;
            startup_cnt <= '0;
            line_addr   <= '0;
            issue_cnt   <= '0;
            rcv_cnt     <= '0;
            data        <= '0;
        end else begin
            state <= state_next;
            if (state == S_STARTUP)
                startup_cnt <= startup_cnt + SW'(1);
            if ((state == S_IDLE) && rd) begin
                line_addr <= addr;
                issue_cnt <= '0;
                rcv_cnt   <= '0;
            end
            if (issue_accept)
                issue_cnt <= issue_cnt + 4'd1;
            if (beat_capture) begin
                data[{rcv_cnt[2:0], 4'b0000} +: 16] <= avm_readdata;
                rcv_cnt <= rcv_cnt + 4'd1;
            end
        end
    end

endmodule
